// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU (alu_seq) and its iterative
// multiply/divide datapath (alu_iter_muldiv).
//   - OP_* : 4-bit opcode map. Codes 10-15 are illegal.
//   - state_t : control states of the top-level handshake FSM.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_NOT = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_ADD = 4'd6;
    localparam logic [3:0] OP_SUB = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// ---------------------------------------------------------------------------
// alu_iter_muldiv
// Shared WIDTH-cycle datapath for MUL (shift-add, LSB first) and DIV
// (restoring, MSB first). One multiplier/quotient bit per enabled cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : load operands and arm the counter (counter = WIDTH-1)
//   mode_div     : 0 = MUL, 1 = DIV (sampled on start)
//   op_a, op_b   : operand1 / operand2 (sampled on start)
//   step         : perform one iteration this cycle
//   done         : last iteration happens at the coming clock edge
//   res_next     : result after this cycle's iteration (valid with done)
//   rem_next     : remainder after this cycle's iteration (0 for MUL)
// ---------------------------------------------------------------------------
module alu_iter_muldiv #(
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             step,
    output logic             done,
    output logic [WIDTH-1:0] res_next,
    output logic [WIDTH-1:0] rem_next
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // acc  : MUL partial product / DIV partial remainder
    // sreg : MUL multiplier (shifts right) / DIV dividend-then-quotient
    // aux  : MUL multiplicand (shifts left) / DIV divisor (constant)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] aux_q, aux_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Next-state for the datapath. On start the operands are steered into
    // the roles of the selected algorithm; on step one iteration runs.
    // For DIV the trial subtraction is one bit wider than the operands so
    // its top bit directly tells whether the divisor fit (restoring step).
    always_comb begin
        acc_d   = acc_q;
        sreg_d  = sreg_q;
        aux_d   = aux_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        shifted = {acc_q, sreg_q[WIDTH-1]};
        diff    = shifted - {1'b0, aux_q};

        if (start) begin
            mode_d = mode_div;
            cnt_d  = CNT_LAST;
            acc_d  = '0;
            if (mode_div) begin
                sreg_d = op_a;
                aux_d  = op_b;
            end else begin
                sreg_d = op_b;
                aux_d  = op_a;
            end
        end else if (step) begin
            if (mode_q) begin
                acc_d  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                sreg_d = {sreg_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                acc_d  = sreg_q[0] ? (acc_q + aux_q) : acc_q;
                sreg_d = sreg_q >> 1;
                aux_d  = aux_q << 1;
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Datapath registers; reset clears accumulators and counter so an
    // aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sreg_q <= '0;
            aux_q  <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            sreg_q <= sreg_d;
            aux_q  <= aux_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    // The final iteration's values are handed out combinationally so the
    // top can register them on the same edge it moves to DONE.
    always_comb begin
        done     = step && (cnt_q == '0);
        res_next = mode_q ? sreg_d : acc_d;
        rem_next = mode_q ? acc_d : '0;
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Sequential integer/logic ALU with valid/ready handshakes on both sides,
// registered outputs and iterative MUL/DIV. One operation in flight.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (accept only in IDLE)
//   alu_op              : 0 AND,1 OR,2 XOR,3 NOT,4 SRL,5 SLL,6 ADD,7 SUB,
//                         8 MUL,9 DIV, 10-15 illegal
//   operand1, operand2  : unsigned operands
//   out_valid/out_ready : result handshake (valid while in DONE)
//   result, remainder   : registered result; remainder is 0 except for DIV
//   flag_zero           : result == 0
//   flag_dbz            : DIV with operand2 == 0
//   flag_illegal        : opcode 10-15
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             flag_zero,
    output logic             flag_dbz,
    output logic             flag_illegal
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             flag_zero_q, flag_zero_d;
    logic             flag_dbz_q, flag_dbz_d;
    logic             flag_illegal_q, flag_illegal_d;

    logic [WIDTH-1:0] simple_res;
    logic [WIDTH-1:0] simple_rem;
    logic             simple_dbz;
    logic             simple_ill;
    logic             needs_iter;
    logic [SHW-1:0]   shamt;

    logic             iter_start;
    logic             iter_step;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic [WIDTH-1:0] iter_rem;

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .CW    (SHW)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (iter_start),
        .mode_div (alu_op == OP_DIV),
        .op_a     (operand1),
        .op_b     (operand2),
        .step     (iter_step),
        .done     (iter_done),
        .res_next (iter_res),
        .rem_next (iter_rem)
    );

    // Single-cycle operations. DIV here only covers the divide-by-zero
    // shortcut; a real division goes through the iterative datapath.
    // Only the low SHW bits of operand2 form the shift amount.
    always_comb begin
        simple_res = '0;
        simple_rem = '0;
        simple_dbz = 1'b0;
        simple_ill = 1'b0;
        shamt      = operand2[SHW-1:0];
        case (alu_op)
            OP_AND: simple_res = operand1 & operand2;
            OP_OR:  simple_res = operand1 | operand2;
            OP_XOR: simple_res = operand1 ^ operand2;
            OP_NOT: simple_res = ~operand1;
            OP_SRL: simple_res = operand1 >> shamt;
            OP_SLL: simple_res = operand1 << shamt;
            OP_ADD: simple_res = operand1 + operand2;
            OP_SUB: simple_res = operand1 - operand2;
            OP_MUL: simple_res = '0;
            OP_DIV: begin
                simple_res = '1;
                simple_rem = operand1;
                simple_dbz = 1'b1;
            end
            default: simple_ill = 1'b1;
        endcase
        needs_iter = (alu_op == OP_MUL) ||
                     ((alu_op == OP_DIV) && (operand2 != '0));
    end

    // Control FSM and output-register load. Results are loaded either at
    // the accept edge (single-cycle ops, DBZ, illegal) or at the edge that
    // completes the last iteration, so flag_zero always matches result.
    always_comb begin
        state_d        = state_q;
        result_d       = result_q;
        remainder_d    = remainder_q;
        flag_zero_d    = flag_zero_q;
        flag_dbz_d     = flag_dbz_q;
        flag_illegal_d = flag_illegal_q;
        iter_start     = 1'b0;
        iter_step      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (needs_iter) begin
                        iter_start = 1'b1;
                        state_d    = BUSY;
                    end else begin
                        state_d        = DONE;
                        result_d       = simple_res;
                        remainder_d    = simple_rem;
                        flag_zero_d    = (simple_res == '0);
                        flag_dbz_d     = simple_dbz;
                        flag_illegal_d = simple_ill;
                    end
                end
            end
            BUSY: begin
                iter_step = 1'b1;
                if (iter_done) begin
                    state_d        = DONE;
                    result_d       = iter_res;
                    remainder_d    = iter_rem;
                    flag_zero_d    = (iter_res == '0);
                    flag_dbz_d     = 1'b0;
                    flag_illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            result_q       <= '0;
            remainder_q    <= '0;
            flag_zero_q    <= 1'b0;
            flag_dbz_q     <= 1'b0;
            flag_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            remainder_q    <= remainder_d;
            flag_zero_q    <= flag_zero_d;
            flag_dbz_q     <= flag_dbz_d;
            flag_illegal_q <= flag_illegal_d;
        end
    end

    // Handshake outputs are decoded straight from the state register.
    always_comb begin
        in_ready     = (state_q == IDLE);
        out_valid    = (state_q == DONE);
        result       = result_q;
        remainder    = remainder_q;
        flag_zero    = flag_zero_q;
        flag_dbz     = flag_dbz_q;
        flag_illegal = flag_illegal_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq at WIDTH=64 and WIDTH=16, with hand-computed
// expected values. Latency is counted as 1 when out_valid is high just after
// the accept edge, plus one per further clock edge.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [63:0] operand1;
    logic [63:0] operand2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [63:0] remainder;
    logic        flag_zero;
    logic        flag_dbz;
    logic        flag_illegal;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [3:0]  s_alu_op;
    logic [15:0] s_operand1;
    logic [15:0] s_operand2;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_result;
    logic [15:0] s_remainder;
    logic        s_flag_zero;
    logic        s_flag_dbz;
    logic        s_flag_illegal;

    int checks;
    int errors;
    int lat;

    alu_seq #(.WIDTH(64)) dut64 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .operand1     (operand1),
        .operand2     (operand2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .remainder    (remainder),
        .flag_zero    (flag_zero),
        .flag_dbz     (flag_dbz),
        .flag_illegal (flag_illegal)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (s_in_valid),
        .in_ready     (s_in_ready),
        .alu_op       (s_alu_op),
        .operand1     (s_operand1),
        .operand2     (s_operand2),
        .out_valid    (s_out_valid),
        .out_ready    (s_out_ready),
        .result       (s_result),
        .remainder    (s_remainder),
        .flag_zero    (s_flag_zero),
        .flag_dbz     (s_flag_dbz),
        .flag_illegal (s_flag_illegal)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit in case a wait goes astray.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request to the 64-bit DUT, scramble the operands after the
    // accept edge, and count cycles until out_valid rises.
    task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b, output int latency);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        checkOutput("issue_ready64", {63'd0, in_ready}, 64'd1);
        alu_op   = op;
        operand1 = a;
        operand2 = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        operand1 = ~a;
        operand2 = '0;
        latency  = 1;
        while (!out_valid && latency < 200) begin
            step();
            latency++;
        end
    endtask

    task automatic applyStimulus16(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, output int latency);
        int guard;
        guard = 0;
        while (!s_in_ready && guard < 100) begin
            step();
            guard++;
        end
        checkOutput("issue_ready16", {63'd0, s_in_ready}, 64'd1);
        s_alu_op   = op;
        s_operand1 = a;
        s_operand2 = b;
        s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        s_operand1 = ~a;
        s_operand2 = '0;
        latency    = 1;
        while (!s_out_valid && latency < 200) begin
            step();
            latency++;
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alu_op      = 4'd0;
        operand1    = '0;
        operand2    = '0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_alu_op    = 4'd0;
        s_operand1  = '0;
        s_operand2  = '0;
        s_out_ready = 1'b1;

        // Reset state
        step();
        step();
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_result", result, 64'd0);
        checkOutput("rst_remainder", remainder, 64'd0);
        checkOutput("rst_flags", {61'd0, flag_zero, flag_dbz, flag_illegal}, 64'd0);
        rst_n = 1'b1;
        step();
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // ADD wraps to zero
        applyStimulus(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat);
        checkOutput("add_latency", 64'(lat), 64'd1);
        checkOutput("add_result", result, 64'd0);
        checkOutput("add_zero", {63'd0, flag_zero}, 64'd1);
        checkOutput("add_in_ready_done", {63'd0, in_ready}, 64'd0);
        step();
        checkOutput("add_one_cycle", {63'd0, out_valid}, 64'd0);

        // Shifts: only low 6 bits of operand2 count
        applyStimulus(4'd5, 64'd1, 64'h43, lat);
        checkOutput("sll_latency", 64'(lat), 64'd1);
        checkOutput("sll_result", result, 64'h8);
        checkOutput("sll_zero", {63'd0, flag_zero}, 64'd0);
        step();
        applyStimulus(4'd4, 64'h8000_0000_0000_0000, 64'd63, lat);
        checkOutput("srl_result", result, 64'd1);
        step();

        // Logic and SUB
        applyStimulus(4'd0, 64'hF0F0, 64'hFF00, lat);
        checkOutput("and_result", result, 64'hF000);
        step();
        applyStimulus(4'd1, 64'h0F, 64'hF0, lat);
        checkOutput("or_result", result, 64'hFF);
        step();
        applyStimulus(4'd2, 64'hAA, 64'hFF, lat);
        checkOutput("xor_result", result, 64'h55);
        step();
        applyStimulus(4'd3, 64'd0, 64'h1234, lat);
        checkOutput("not_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        applyStimulus(4'd7, 64'd3, 64'd5, lat);
        checkOutput("sub_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("sub_remainder", remainder, 64'd0);
        step();

        // DIV 100 / 7
        applyStimulus(4'd9, 64'd100, 64'd7, lat);
        checkOutput("div_latency", 64'(lat), 64'd65);
        checkOutput("div_quotient", result, 64'd14);
        checkOutput("div_remainder", remainder, 64'd2);
        checkOutput("div_flags", {61'd0, flag_zero, flag_dbz, flag_illegal}, 64'd0);
        step();
        checkOutput("div_one_cycle", {63'd0, out_valid}, 64'd0);

        // MUL low 64 bits
        applyStimulus(4'd8, 64'h1_0000_0000, 64'h1_0000_0001, lat);
        checkOutput("mul_latency", 64'(lat), 64'd65);
        checkOutput("mul_result", result, 64'h1_0000_0000);
        checkOutput("mul_remainder", remainder, 64'd0);
        step();
        applyStimulus(4'd8, 64'd12345, 64'd678, lat);
        checkOutput("mul_small", result, 64'd8369910);
        step();

        // Divide by zero
        applyStimulus(4'd9, 64'd5, 64'd0, lat);
        checkOutput("dbz_latency", 64'(lat), 64'd1);
        checkOutput("dbz_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("dbz_remainder", remainder, 64'd5);
        checkOutput("dbz_flags", {61'd0, flag_zero, flag_dbz, flag_illegal}, 64'b010);
        step();

        // Illegal opcode
        applyStimulus(4'd12, 64'd9, 64'd9, lat);
        checkOutput("ill_latency", 64'(lat), 64'd1);
        checkOutput("ill_result", result, 64'd0);
        checkOutput("ill_flags", {61'd0, flag_zero, flag_dbz, flag_illegal}, 64'b101);
        step();

        // Backpressure after a MUL: outputs held, no new accept
        out_ready = 1'b0;
        applyStimulus(4'd8, 64'd7, 64'd6, lat);
        checkOutput("bp_latency", 64'(lat), 64'd65);
        alu_op   = 4'd6;
        operand1 = 64'd1;
        operand2 = 64'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_result", result, 64'd42);
            checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("bp_release_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("bp_release_ready", {63'd0, in_ready}, 64'd1);
        step();
        checkOutput("bp_no_accept", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of a DIV
        alu_op   = 4'd9;
        operand1 = 64'd1000;
        operand2 = 64'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        checkOutput("abort_busy", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("abort_result", result, 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            checkOutput("abort_no_result", {63'd0, out_valid}, 64'd0);
        end
        applyStimulus(4'd6, 64'd3, 64'd4, lat);
        checkOutput("post_abort_add", result, 64'd7);
        step();

        // WIDTH=16 instance
        applyStimulus16(4'd9, 16'd100, 16'd7, lat);
        checkOutput("w16_div_latency", 64'(lat), 64'd17);
        checkOutput("w16_div_quotient", {48'd0, s_result}, 64'd14);
        checkOutput("w16_div_remainder", {48'd0, s_remainder}, 64'd2);
        step();
        applyStimulus16(4'd9, 16'hFFFF, 16'h10, lat);
        checkOutput("w16_div2_quotient", {48'd0, s_result}, 64'hFFF);
        checkOutput("w16_div2_remainder", {48'd0, s_remainder}, 64'hF);
        step();
        applyStimulus16(4'd8, 16'h1234, 16'h10, lat);
        checkOutput("w16_mul_latency", 64'(lat), 64'd17);
        checkOutput("w16_mul_result", {48'd0, s_result}, 64'h2340);
        step();
        applyStimulus16(4'd8, 16'hFFFF, 16'hFFFF, lat);
        checkOutput("w16_mul_wrap", {48'd0, s_result}, 64'h0001);
        checkOutput("w16_mul_zero", {63'd0, s_flag_zero}, 64'd0);
        step();
        applyStimulus16(4'd5, 16'd1, 16'h1F, lat);
        checkOutput("w16_sll_result", {48'd0, s_result}, 64'h8000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the integer/logic ALU. Same 4-bit opcode map.
- Adds a valid/ready handshake on both sides, registered outputs, and iterative multi-cycle MUL/DIV.
- Adds a remainder output and status flags: divide-by-zero, illegal opcode, zero result.
- Sits between the issue stage and writeback. Holds at most one operation in flight.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a power of two, ≥8.
- SHW, $clog2(WIDTH), number of low operand2 bits used as shift amount.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- alu_op  in  4  0 AND, 1 OR, 2 XOR, 3 NOT, 4 SRL, 5 SLL, 6 ADD, 7 SUB, 8 MUL, 9 DIV; 10-15 illegal
- operand1  in  WIDTH  first operand, unsigned
- operand2  in  WIDTH  second operand, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- remainder  out  WIDTH  DIV remainder; 0 for all other ops
- flag_zero  out  1  result == 0
- flag_dbz  out  1  DIV with operand2 == 0
- flag_illegal  out  1  opcode 10-15

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=1 once rst_n is deasserted.
  - out_valid=0; result, remainder and all flags = 0.
  - Internal accumulators and counter cleared.
  - Reset asserted mid-operation aborts the operation; no result is ever presented for it.
- States:
  - IDLE: in_ready=1. Accept when in_valid=1.
    - Ops 0-7, illegal opcode, and DIV by zero → DONE.
    - MUL/DIV → BUSY, with operands latched and counter = WIDTH-1.
  - BUSY: in_ready=0. One iteration per cycle.
    - Leave for DONE when counter==0 at a clock edge; otherwise decrement.
    - Exactly WIDTH cycles are spent in BUSY.
  - DONE: out_valid=1. Outputs are stable and held until out_ready=1, then → IDLE.
- Throughput and latency:
  - in_ready is 0 in DONE, so there is no accept in the DONE→IDLE cycle; throughput is at most one op per 2 cycles.
  - Ops 0-7, illegal and DBZ: out_valid rises 1 cycle after the accept edge.
  - MUL/DIV: out_valid rises WIDTH+1 cycles after the accept edge.
- Arithmetic (all modulo 2^WIDTH):
  - ADD/SUB wrap. MUL returns the low WIDTH bits of the product.
  - SRL/SLL are logical shifts by operand2[SHW-1:0]; upper bits of operand2 are ignored.
  - NOT ignores operand2.
- MUL: shift-add algorithm, one multiplier bit per cycle, LSB first.
- DIV: restoring algorithm, one quotient bit per cycle, MSB first. result = quotient, remainder = remainder.
- DIV by zero: no iteration. result = all ones, remainder = operand1, flag_dbz=1.
- Illegal opcode: result=0, flag_illegal=1, flag_zero=1.
- flag_zero is computed from the final result and is registered together with it.
- Operand inputs and in_valid are ignored outside IDLE; changes during BUSY have no effect.
- out_ready held high continuously: the result is still presented for exactly one cycle per op.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_AND … OP_DIV (4-bit).
  - State enum {IDLE, BUSY, DONE}.
- One natural sub-module, alu_iter_muldiv:
  - Holds the shared WIDTH-cycle datapath: accumulator, shift register, counter.
  - Selected by a mul/div mode bit; reports done.
  - Ops 0-7 remain inline combinational logic feeding the output register.

Test Plan:
- ADD: WIDTH=64, op=6, operand1=0xFFFF_FFFF_FFFF_FFFF, operand2=1 → out_valid 1 cycle after accept, result=0, flag_zero=1.
- SLL with ignored shift bits: op=5, operand1=1, operand2=0x43 → result=0x8 (shift 3, bit 6 ignored); SRL of 0x8000_0000_0000_0000 by 63 → result=1.
- DIV: op=9, operand1=100, operand2=7 → out_valid exactly 65 cycles after accept, result=14, remainder=2; MUL 0x1_0000_0000 × 0x1_0000_0001 → result=0x1_0000_0000 (low 64 bits).
- DBZ and illegal: op=9, operand1=5, operand2=0 → 1-cycle latency, result=all ones, remainder=5, flag_dbz=1. op=12 → result=0, flag_illegal=1.
- Backpressure: hold out_ready=0 for 10 cycles after a MUL completes → out_valid and outputs stable, in_ready=0, and a new in_valid is not accepted; raise out_ready → IDLE next cycle.
- Abort and parameter sweep: drop rst_n 20 cycles into a DIV → out_valid=0 immediately; after release a fresh ADD 3+4 returns 7. Repeat MUL/DIV checks with WIDTH=16 (latency 17).
